// File: rtl/mem_pipe_stage_pkg.sv
// rtl/mem_pipe_stage_pkg.sv - default widths and write-back bundle type for the MEM/WB stage
package risc_pipe_pkg;

    localparam int WR_ID_W  = 5;
    localparam int FMASK_W  = 8;
    localparam int RESULT_W = 16;
    localparam int FLAGS_W  = 8;

    typedef struct packed {
        logic [WR_ID_W-1:0]  wr_id;
        logic [FMASK_W-1:0]  fmask;
        logic [RESULT_W-1:0] result;
        logic [FLAGS_W-1:0]  flags;
    } wb_bundle_t;

endpackage

// File: rtl/mem_pipe_stage_if.sv
// rtl/mem_pipe_stage_if.sv - MEM-side and WB-side handshake bundle of the MEM/WB stage
interface mem_pipe_stage_if #(
    parameter int WR_ID_W  = risc_pipe_pkg::WR_ID_W,
    parameter int FMASK_W  = risc_pipe_pkg::FMASK_W,
    parameter int RESULT_W = risc_pipe_pkg::RESULT_W,
    parameter int FLAGS_W  = risc_pipe_pkg::FLAGS_W
);
    import risc_pipe_pkg::*;

    logic                in_valid;
    logic                in_ready;
    logic [WR_ID_W-1:0]  in_wr_id;
    logic [FMASK_W-1:0]  in_fmask;
    logic [RESULT_W-1:0] in_result;
    logic [FLAGS_W-1:0]  in_flags;

    logic                out_valid;
    logic                out_ready;
    logic [WR_ID_W-1:0]  out_wr_id;
    logic [FMASK_W-1:0]  out_fmask;
    logic [RESULT_W-1:0] out_result;
    logic [FLAGS_W-1:0]  out_flags;

    modport master (
        output in_valid, in_wr_id, in_fmask, in_result, in_flags,
        input  in_ready,
        input  out_valid, out_wr_id, out_fmask, out_result, out_flags,
        output out_ready
    );

    modport slave (
        input  in_valid, in_wr_id, in_fmask, in_result, in_flags,
        output in_ready,
        output out_valid, out_wr_id, out_fmask, out_result, out_flags,
        input  out_ready
    );

endinterface

// File: rtl/mem_pipe_slot.sv
// rtl/mem_pipe_slot.sv - one valid bit plus payload entry with load and clear controls
module mem_pipe_slot
    import risc_pipe_pkg::*;
#(
    parameter int W = 1
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic         clear_i,
    input  logic [W-1:0] data_i,
    output logic         valid_o,
    output logic [W-1:0] data_o
);

    logic         valid_q, valid_d;
    logic [W-1:0] data_q, data_d;

    // Load wins over clear so an entry can be refilled on the cycle it drains;
    // clear only drops the valid bit and leaves the payload in place.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end else if (clear_i) begin
            valid_d = 1'b0;
        end
    end

    // Entry register, zeroed by reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/mem_pipe_stage.sv
// rtl/mem_pipe_stage.sv - MEM/WB handshake stage; MEM_PIPE_STAGE_SKID_EN adds a skid entry
module mem_pipe_stage #(
    parameter int WR_ID_W  = risc_pipe_pkg::WR_ID_W,
    parameter int FMASK_W  = risc_pipe_pkg::FMASK_W,
    parameter int RESULT_W = risc_pipe_pkg::RESULT_W,
    parameter int FLAGS_W  = risc_pipe_pkg::FLAGS_W
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              stall,
    input  logic              flush,
    output logic [1:0]        occupancy,
    mem_pipe_stage_if.slave   bus
);
    import risc_pipe_pkg::*;

    localparam int BUNDLE_W = WR_ID_W + FMASK_W + RESULT_W + FLAGS_W;

    logic [BUNDLE_W-1:0] in_bundle;
    logic [BUNDLE_W-1:0] m_next;
    logic [BUNDLE_W-1:0] m_data;
    logic                m_valid;
    logic                m_load;
    logic                m_clear;
    logic                in_xfer;
    logic                out_xfer;

    assign in_bundle = {bus.in_wr_id, bus.in_fmask, bus.in_result, bus.in_flags};
    assign {bus.out_wr_id, bus.out_fmask, bus.out_result, bus.out_flags} = m_data;

    // During flush out_valid still shows the old M so a same-cycle consume is honoured.
    assign bus.out_valid = m_valid & !stall;
    assign in_xfer       = bus.in_valid & bus.in_ready;
    assign out_xfer      = bus.out_valid & bus.out_ready;

    mem_pipe_slot #(.W(BUNDLE_W)) u_main (
        .clk_i   (CLK),
        .rst_ni  (RST_N),
        .load_i  (m_load),
        .clear_i (m_clear),
        .data_i  (m_next),
        .valid_o (m_valid),
        .data_o  (m_data)
    );

`ifdef MEM_PIPE_STAGE_SKID_EN
    logic                s_valid;
    logic                s_load;
    logic                s_clear;
    logic [BUNDLE_W-1:0] s_data;

    // in_ready depends only on registered S occupancy, cutting the out_ready path.
    assign bus.in_ready = !s_valid & !stall & !flush;
    assign m_next       = s_valid ? s_data : in_bundle;
    assign occupancy    = {1'b0, m_valid} + {1'b0, s_valid};

    // Slot controls: S catches the in-flight bundle when WB stalls, and refills M first on drain.
    always_comb begin
        m_load  = 1'b0;
        m_clear = 1'b0;
        s_load  = 1'b0;
        s_clear = 1'b0;
        if (!stall) begin
            if (flush) begin
                m_clear = 1'b1;
                s_clear = 1'b1;
            end else if (!m_valid) begin
                m_load = in_xfer;
            end else if (out_xfer) begin
                if (s_valid) begin
                    m_load  = 1'b1;
                    s_clear = 1'b1;
                end else if (in_xfer) begin
                    m_load = 1'b1;
                end else begin
                    m_clear = 1'b1;
                end
            end else begin
                s_load = in_xfer;
            end
        end
    end

    mem_pipe_slot #(.W(BUNDLE_W)) u_skid (
        .clk_i   (CLK),
        .rst_ni  (RST_N),
        .load_i  (s_load),
        .clear_i (s_clear),
        .data_i  (in_bundle),
        .valid_o (s_valid),
        .data_o  (s_data)
    );
`else
    // Single entry: accept whenever M is empty or is being consumed this cycle.
    assign bus.in_ready = !stall & !flush & (!m_valid | bus.out_ready);
    assign m_next       = in_bundle;
    assign occupancy    = {1'b0, m_valid};

    // M control: load on accept, empty on consume without a replacement.
    always_comb begin
        m_load  = 1'b0;
        m_clear = 1'b0;
        if (!stall) begin
            if (flush) begin
                m_clear = 1'b1;
            end else begin
                m_load  = in_xfer;
                m_clear = out_xfer & !in_xfer;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_pipe_stage.sv
// tb/tb_mem_pipe_stage.sv - directed self-checking bench for mem_pipe_stage
module tb_mem_pipe_stage;
    import risc_pipe_pkg::*;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       stall = 1'b0;
    logic       flush = 1'b0;
    logic [1:0] occupancy;
    int         total = 0;
    int         bad = 0;

    mem_pipe_stage_if #(.WR_ID_W(WR_ID_W), .FMASK_W(FMASK_W), .RESULT_W(RESULT_W), .FLAGS_W(FLAGS_W)) bus ();

    mem_pipe_stage #(.WR_ID_W(WR_ID_W), .FMASK_W(FMASK_W), .RESULT_W(RESULT_W), .FLAGS_W(FLAGS_W)) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .stall     (stall),
        .flush     (flush),
        .occupancy (occupancy),
        .bus       (bus)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic drive(input logic v, input int id, input logic [15:0] res);
        bus.in_valid  = v;
        bus.in_wr_id  = id[4:0];
        bus.in_fmask  = id[7:0];
        bus.in_result = res;
        bus.in_flags  = ~id[7:0];
    endtask

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        bus.out_ready = 1'b1;
        drive(1'b1, 31, 16'hBEEF);
        next_cycle();
        next_cycle();
        #1;
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
        total++; if (bus.out_result !== 16'h0) begin bad++; $display("FAIL reset_out_result got=%h exp=0000", bus.out_result); end
        total++; if (bus.out_wr_id !== 5'h0) begin bad++; $display("FAIL reset_out_wr_id got=%h exp=00", bus.out_wr_id); end
        total++; if (bus.out_fmask !== 8'h0 || bus.out_flags !== 8'h0) begin bad++; $display("FAIL reset_out_fmask_flags got=%h/%h exp=00/00", bus.out_fmask, bus.out_flags); end
        total++; if (occupancy !== 2'd0) begin bad++; $display("FAIL reset_occupancy got=%0d exp=0", occupancy); end
        RST_N = 1'b1;
        drive(1'b0, 0, 16'h0);
        next_cycle();
        total++; if (bus.out_valid !== 1'b0 || occupancy !== 2'd0) begin bad++; $display("FAIL post_reset_idle got=%b/%0d exp=0/0", bus.out_valid, occupancy); end
    endtask

    task automatic test_streaming();
        logic exp_v;
        bus.out_ready = 1'b1;
        for (int n = 1; n <= 9; n++) begin
            if (n <= 8) drive(1'b1, n, 16'h1000 + 16'(n));
            else        drive(1'b0, 0, 16'h0);
            #1;
            exp_v = (n > 1);
            total++; if (bus.out_valid !== exp_v) begin bad++; $display("FAIL stream_valid n=%0d got=%b exp=%b", n, bus.out_valid, exp_v); end
            if (n > 1) begin
                total++; if (bus.out_wr_id !== 5'(n - 1)) begin bad++; $display("FAIL stream_wr_id n=%0d got=%0d exp=%0d", n, bus.out_wr_id, n - 1); end
                total++; if (bus.out_result !== 16'h1000 + 16'(n - 1)) begin bad++; $display("FAIL stream_result n=%0d got=%h exp=%h", n, bus.out_result, 16'h1000 + 16'(n - 1)); end
                total++; if (bus.out_flags !== ~8'(n - 1)) begin bad++; $display("FAIL stream_flags n=%0d got=%h exp=%h", n, bus.out_flags, ~8'(n - 1)); end
                total++; if (occupancy !== 2'd1) begin bad++; $display("FAIL stream_occupancy n=%0d got=%0d exp=1", n, occupancy); end
            end
            if (n <= 8) begin
                total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL stream_in_ready n=%0d got=%b exp=1", n, bus.in_ready); end
            end
            next_cycle();
        end
        total++; if (bus.out_valid !== 1'b0 || occupancy !== 2'd0) begin bad++; $display("FAIL stream_drained got=%b/%0d exp=0/0", bus.out_valid, occupancy); end
    endtask

    task automatic test_flush();
        logic [1:0] exp_occ;
        bus.out_ready = 1'b0;
        drive(1'b1, 9, 16'h2009);
        #1;
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL flush_fill_ready got=%b exp=1", bus.in_ready); end
        next_cycle();
`ifdef MEM_PIPE_STAGE_SKID_EN
        drive(1'b1, 10, 16'h200A);
        #1;
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL flush_fill_skid_ready got=%b exp=1", bus.in_ready); end
        next_cycle();
        exp_occ = 2'd2;
`else
        exp_occ = 2'd1;
`endif
        drive(1'b1, 11, 16'h200B);
        flush = 1'b1;
        #1;
        total++; if (occupancy !== exp_occ) begin bad++; $display("FAIL flush_pre_occupancy got=%0d exp=%0d", occupancy, exp_occ); end
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL flush_in_ready got=%b exp=0", bus.in_ready); end
        total++; if (bus.out_valid !== 1'b1 || bus.out_result !== 16'h2009) begin bad++; $display("FAIL flush_pre_out got=%b/%h exp=1/2009", bus.out_valid, bus.out_result); end
        next_cycle();
        flush = 1'b0;
        drive(1'b0, 0, 16'h0);
        #1;
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL flush_out_valid got=%b exp=0", bus.out_valid); end
        total++; if (occupancy !== 2'd0) begin bad++; $display("FAIL flush_occupancy got=%0d exp=0", occupancy); end
        total++; if (bus.out_result !== 16'h2009) begin bad++; $display("FAIL flush_payload_kept got=%h exp=2009", bus.out_result); end
        next_cycle();
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL flush_input_dropped got=%b exp=0", bus.out_valid); end
    endtask

    task automatic test_stall_flush();
        bus.out_ready = 1'b0;
        drive(1'b1, 3, 16'h00A5);
        next_cycle();
        drive(1'b1, 4, 16'h0BAD);
        stall = 1'b1;
        flush = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL stall_out_valid got=%b exp=0", bus.out_valid); end
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL stall_in_ready got=%b exp=0", bus.in_ready); end
        total++; if (bus.out_result !== 16'h00A5) begin bad++; $display("FAIL stall_data_hold got=%h exp=00a5", bus.out_result); end
        next_cycle();
        total++; if (bus.out_valid !== 1'b0 || occupancy !== 2'd1) begin bad++; $display("FAIL stall_frozen got=%b/%0d exp=0/1", bus.out_valid, occupancy); end
        next_cycle();
        stall = 1'b0;
        flush = 1'b0;
        bus.out_ready = 1'b0;
        drive(1'b0, 0, 16'h0);
        #1;
        total++; if (bus.out_valid !== 1'b1 || bus.out_result !== 16'h00A5) begin bad++; $display("FAIL stall_represent got=%b/%h exp=1/00a5", bus.out_valid, bus.out_result); end
        total++; if (bus.out_wr_id !== 5'd3 || occupancy !== 2'd1) begin bad++; $display("FAIL stall_represent_id got=%0d/%0d exp=3/1", bus.out_wr_id, occupancy); end
        bus.out_ready = 1'b1;
        next_cycle();
        total++; if (bus.out_valid !== 1'b0 || occupancy !== 2'd0) begin bad++; $display("FAIL stall_drain got=%b/%0d exp=0/0", bus.out_valid, occupancy); end
    endtask

`ifdef MEM_PIPE_STAGE_SKID_EN
    task automatic test_backpressure();
        int sent = 1;
        int exp_id = 1;
        int cyc = 0;
        while (exp_id <= 8 && cyc < 40) begin
            bus.out_ready = !(cyc >= 3 && cyc <= 5);
            if (sent <= 8) drive(1'b1, sent, 16'h4000 + 16'(sent));
            else           drive(1'b0, 0, 16'h0);
            #1;
            if (cyc == 3) begin
                total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_lag got=%b exp=1", bus.in_ready); end
            end
            if (cyc == 4) begin
                total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL bp_ready_low got=%b exp=0", bus.in_ready); end
                total++; if (occupancy !== 2'd2) begin bad++; $display("FAIL bp_occupancy got=%0d exp=2", occupancy); end
            end
            if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
                total++; if (bus.out_wr_id !== 5'(exp_id) || bus.out_result !== 16'h4000 + 16'(exp_id)) begin bad++; $display("FAIL bp_order got=%0d/%h exp=%0d/%h", bus.out_wr_id, bus.out_result, exp_id, 16'h4000 + 16'(exp_id)); end
                exp_id++;
            end
            if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1) sent++;
            next_cycle();
            cyc++;
        end
        total++; if (exp_id != 9) begin bad++; $display("FAIL bp_delivered got=%0d exp=8", exp_id - 1); end
        total++; if (bus.out_valid !== 1'b0 || occupancy !== 2'd0) begin bad++; $display("FAIL bp_drained got=%b/%0d exp=0/0", bus.out_valid, occupancy); end
    endtask
`else
    task automatic test_nonskid();
        bus.out_ready = 1'b0;
        drive(1'b1, 6, 16'h3006);
        next_cycle();
        drive(1'b1, 7, 16'h3007);
        #1;
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL ns_ready_blocked got=%b exp=0", bus.in_ready); end
        total++; if (bus.out_valid !== 1'b1 || bus.out_result !== 16'h3006) begin bad++; $display("FAIL ns_held got=%b/%h exp=1/3006", bus.out_valid, bus.out_result); end
        bus.out_ready = 1'b1;
        #1;
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL ns_ready_comb got=%b exp=1", bus.in_ready); end
        next_cycle();
        drive(1'b0, 0, 16'h0);
        #1;
        total++; if (bus.out_valid !== 1'b1 || bus.out_result !== 16'h3007) begin bad++; $display("FAIL ns_swap got=%b/%h exp=1/3007", bus.out_valid, bus.out_result); end
        total++; if (occupancy !== 2'd1) begin bad++; $display("FAIL ns_occupancy got=%0d exp=1", occupancy); end
        next_cycle();
        total++; if (bus.out_valid !== 1'b0 || occupancy !== 2'd0) begin bad++; $display("FAIL ns_drained got=%b/%0d exp=0/0", bus.out_valid, occupancy); end
    endtask
`endif

    initial begin
        bus.out_ready = 1'b0;
        drive(1'b0, 0, 16'h0);
        test_reset();
        test_streaming();
        test_flush();
        test_stall_flush();
`ifdef MEM_PIPE_STAGE_SKID_EN
        test_backpressure();
`else
        test_nonskid();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
